// File: rtl/lcd_evt_pkg.sv
// Shared opcodes, FSM states and queue entry layout for the LCD event scheduler.
package lcd_evt_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = OP_W + DATA_W;

  localparam logic [OP_W-1:0] OP_CHAR_R1  = 2'd0;
  localparam logic [OP_W-1:0] OP_CHAR_R2  = 2'd1;
  localparam logic [OP_W-1:0] OP_TRANSFER = 2'd2;
  localparam logic [OP_W-1:0] OP_CLEAR    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Queue entry {op, data}
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/lcd_evt_fifo.sv
// Synchronous event FIFO with push/pop/flush; flush with push leaves only the pushed entry.
module lcd_evt_fifo
  import lcd_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wr_data,
  output entry_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        count_q <= CW'(1);
      end else begin
        count_q <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_event_scheduler.sv
// Round-robin merge of two display-event requesters into a queued, paced strobe stream
// for the LCD controller. Optional build macro CLEAR_FLUSH_EN: an accepted CLEAR discards
// everything still queued and becomes the only pending entry.
module lcd_event_scheduler
  import lcd_evt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  input  logic [OP_W-1:0]             a_op,
  input  logic [DATA_W-1:0]           a_data,
  output logic                        a_ready,
  input  logic                        b_valid,
  input  logic [OP_W-1:0]             b_op,
  input  logic [DATA_W-1:0]           b_data,
  output logic                        b_ready,
  output logic [DATA_W-1:0]           char_in,
  output logic                        char_valid,
  output logic                        char_to_row2,
  output logic                        transfer_to_row1,
  output logic [DATA_W-1:0]           transfer_char,
  output logic                        clear,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES)) + 1;

  logic       rr_b;
  logic       grant_a, grant_b, push_a, push_b, push, pop, flush;
  logic       fifo_full, fifo_empty;
  entry_t     push_entry, fifo_rd;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [OP_W-1:0]     cur_op_q, cur_op_n;
  logic                char_valid_n, transfer_n, clear_n, char_row2_n;
  logic [DATA_W-1:0]   char_in_n, xfer_char_n;

  // Round-robin grant: rr side wins a tie, a lone requester always wins
  always_comb begin
    grant_a = a_valid & (~b_valid | ~rr_b);
    grant_b = b_valid & (~a_valid |  rr_b);
  end

  assign a_ready = grant_a & ~fifo_full & ~rst;
  assign b_ready = grant_b & ~fifo_full & ~rst;
  assign push_a  = a_valid & a_ready;
  assign push_b  = b_valid & b_ready;
  assign push    = push_a | push_b;

  // Select the payload of the granted side
  always_comb begin
    push_entry = '{op: b_op, data: b_data};
    if (push_a) push_entry = '{op: a_op, data: a_data};
  end

`ifdef CLEAR_FLUSH_EN
  assign flush = push & (push_entry.op == OP_CLEAR);
`else
  assign flush = 1'b0;
`endif

  // Priority flips to the other side after every accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_b <= 1'b0;
    else if (push_a) rr_b <= 1'b1;
    else if (push_b) rr_b <= 1'b0;
  end

  lcd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_entry),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy = (state_q != ST_IDLE) | ~fifo_empty;

  // State, hold/gap counter and current opcode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cur_op_q <= OP_CHAR_R1;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      cur_op_q <= cur_op_n;
    end
  end

  // Next state, pop decision and next strobe/payload values
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    cur_op_n     = cur_op_q;
    pop          = 1'b0;
    char_valid_n = 1'b0;
    transfer_n   = 1'b0;
    clear_n      = 1'b0;
    char_in_n    = char_in;
    char_row2_n  = char_to_row2;
    xfer_char_n  = transfer_char;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_ASSERT;
          cnt_n   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_n = ST_GAP;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_n = ST_IDLE;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    if (pop) begin
      cur_op_n = fifo_rd.op;
      case (fifo_rd.op)
        OP_CHAR_R1, OP_CHAR_R2: begin
          char_in_n   = fifo_rd.data;
          char_row2_n = (fifo_rd.op == OP_CHAR_R2);
        end
        OP_TRANSFER: xfer_char_n = fifo_rd.data;
        default: ;
      endcase
    end

    if (state_n == ST_ASSERT) begin
      case (cur_op_n)
        OP_CHAR_R1, OP_CHAR_R2: char_valid_n = 1'b1;
        OP_TRANSFER:            transfer_n   = 1'b1;
        default:                clear_n      = 1'b1;
      endcase
    end
  end

  // Registered strobes and held payloads toward the LCD controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_valid       <= 1'b0;
      transfer_to_row1 <= 1'b0;
      clear            <= 1'b0;
      char_in          <= '0;
      char_to_row2     <= 1'b0;
      transfer_char    <= '0;
    end else begin
      char_valid       <= char_valid_n;
      transfer_to_row1 <= transfer_n;
      clear            <= clear_n;
      char_in          <= char_in_n;
      char_to_row2     <= char_row2_n;
      transfer_char    <= xfer_char_n;
    end
  end

endmodule

// File: tb/tb_lcd_event_scheduler.sv
// Self-checking bench for lcd_event_scheduler: queue-based behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_lcd_event_scheduler;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned GAP    = 4;
  localparam int unsigned PERIOD = HOLD + GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [1:0] a_op, b_op;
  logic [7:0] a_data, b_data;
  logic [7:0] char_in, transfer_char;
  logic       char_valid, char_to_row2, transfer_to_row1, clear, busy;
  logic [3:0] fifo_count;

  lcd_event_scheduler #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready),
    .char_in(char_in), .char_valid(char_valid), .char_to_row2(char_to_row2),
    .transfer_to_row1(transfer_to_row1), .transfer_char(transfer_char),
    .clear(clear), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; logic [7:0] data; } ev_t;
  typedef struct { int kind; logic [7:0] data; logic row2; int cyc; } rise_t;

  ev_t   a_pend[$], b_pend[$], mq[$];
  ev_t   m_cur;
  rise_t log_q[$];
  int    acc_cyc[$];
  int    m_p = PERIOD;
  bit    m_rr_b = 1'b0;
  logic [7:0] m_char = 8'h00, m_xchar = 8'h00;
  logic  m_row2 = 1'b0;
  int    cyc = 0, n_acc = 0, hi_cv = 0, busy_fall = -1;
  int    n_checks = 0, n_pass = 0;
  logic  prev_cv = 1'b0, prev_tr = 1'b0, prev_cl = 1'b0, prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Requester drivers: present the head of each pending queue, held until accepted
  initial begin
    a_valid = 1'b0; a_op = 2'd0; a_data = 8'h00;
    b_valid = 1'b0; b_op = 2'd0; b_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (a_pend.size() != 0) begin a_valid = 1'b1; a_op = a_pend[0].op; a_data = a_pend[0].data; end
      else begin a_valid = 1'b0; a_op = 2'd0; a_data = 8'h00; end
      if (b_pend.size() != 0) begin b_valid = 1'b1; b_op = b_pend[0].op; b_data = b_pend[0].data; end
      else begin b_valid = 1'b0; b_op = 2'd0; b_data = 8'h00; end
    end
  end

  // Model: queue of events; each popped event owns PERIOD cycles (strobe for cycles 1..HOLD after pop)
  always @(posedge clk or posedge rst) begin : model
    bit   ga, gb, full, acc_a, acc_b;
    ev_t  in_ev;
    if (rst) begin
      mq.delete(); m_p = PERIOD; m_rr_b = 1'b0;
      m_char = 8'h00; m_xchar = 8'h00; m_row2 = 1'b0;
      m_cur = '{2'd0, 8'h00};
    end else begin
      full  = (mq.size() == DEPTH);
      ga    = a_valid && (!b_valid || !m_rr_b);
      gb    = b_valid && (!a_valid || m_rr_b);
      acc_a = ga && !full;
      acc_b = gb && !full;
      if (m_p >= PERIOD && mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_p   = 1;
        if (m_cur.op <= 2'd1) begin m_char = m_cur.data; m_row2 = (m_cur.op == 2'd1); end
        else if (m_cur.op == 2'd2) m_xchar = m_cur.data;
      end else if (m_p < PERIOD) begin
        m_p++;
      end
      if (acc_a || acc_b) begin
        in_ev = acc_a ? '{a_op, a_data} : '{b_op, b_data};
`ifdef CLEAR_FLUSH_EN
        if (in_ev.op == 2'd3) mq.delete();
`endif
        mq.push_back(in_ev);
        m_rr_b = acc_a;
        n_acc++;
        acc_cyc.push_back(cyc);
        if (acc_a) void'(a_pend.pop_front());
        else       void'(b_pend.pop_front());
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, plus strobe-rise logging
  always @(negedge clk) begin : cmp
    bit ga, gb, full, on;
    if (!rst) begin
      full = (mq.size() == DEPTH);
      ga   = a_valid && (!b_valid || !m_rr_b);
      gb   = b_valid && (!a_valid || m_rr_b);
      on   = (m_p >= 1) && (m_p <= HOLD);
      check("a_ready", 32'(a_ready), 32'(ga && !full));
      check("b_ready", 32'(b_ready), 32'(gb && !full));
      check("char_valid", 32'(char_valid), 32'(on && m_cur.op <= 2'd1));
      check("transfer_to_row1", 32'(transfer_to_row1), 32'(on && m_cur.op == 2'd2));
      check("clear", 32'(clear), 32'(on && m_cur.op == 2'd3));
      check("char_in", 32'(char_in), 32'(m_char));
      check("char_to_row2", 32'(char_to_row2), 32'(m_row2));
      check("transfer_char", 32'(transfer_char), 32'(m_xchar));
      check("busy", 32'(busy), 32'(mq.size() != 0 || m_p < PERIOD));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("strobe_overlap", 32'((32'(char_valid) + 32'(transfer_to_row1) + 32'(clear)) > 1), 32'd0);
      if (char_valid && !prev_cv)       log_q.push_back('{0, char_in, char_to_row2, cyc});
      if (transfer_to_row1 && !prev_tr) log_q.push_back('{1, transfer_char, 1'b0, cyc});
      if (clear && !prev_cl)            log_q.push_back('{2, 8'h00, 1'b0, cyc});
      if (char_valid) hi_cv++;
      if (!busy && prev_busy) busy_fall = cyc;
    end
    prev_cv = char_valid; prev_tr = transfer_to_row1; prev_cl = clear; prev_busy = busy;
  end

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (a_pend.size() == 0 && b_pend.size() == 0 && !busy) break;
    end
    check(name, 32'(i >= 600), 32'd0);
  endtask

  initial begin : stim
    int base, n0, i;
    repeat (3) @(negedge clk);
    #1;
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_transfer", 32'(transfer_to_row1), 32'd0);
    check("rst_clear", 32'(clear), 32'd0);
    check("rst_char_in", 32'(char_in), 32'd0);
    check("rst_transfer_char", 32'(transfer_char), 32'd0);
    check("rst_row2", 32'(char_to_row2), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single CHAR_R1 'S'
    hi_cv = 0; base = log_q.size();
    a_pend.push_back('{2'd0, 8'h53});
    drain("t1_drain");
    check("t1_nstrobes", 32'(log_q.size() - base), 32'd1);
    if (log_q.size() > base) begin
      check("t1_kind", 32'(log_q[base].kind), 32'd0);
      check("t1_char", 32'(log_q[base].data), 32'h53);
      check("t1_row2", 32'(log_q[base].row2), 32'd0);
      check("t1_latency", 32'(log_q[base].cyc - acc_cyc[$]), 32'd2);
      check("t1_hold", 32'(hi_cv), 32'd4);
      check("t1_busy_fall", 32'(busy_fall - log_q[base].cyc), 32'd8);
    end

    // Both sides valid every cycle; B holds priority after A's last win
    base = log_q.size();
    for (int k = 0; k < 6; k++) begin
      a_pend.push_back('{2'd0, 8'(8'h61 + k)});
      b_pend.push_back('{2'd0, 8'(8'h41 + k)});
    end
    drain("t2_drain");
    check("t2_nstrobes", 32'(log_q.size() - base), 32'd12);
    if (log_q.size() >= base + 12) begin
      for (int k = 0; k < 12; k++) begin
        check("t2_order", 32'(log_q[base + k].data), (k % 2 == 0) ? 32'(8'h41 + k / 2) : 32'(8'h61 + k / 2));
        if (k > 0) check("t2_period", 32'(log_q[base + k].cyc - log_q[base + k - 1].cyc), 32'd9);
      end
    end

    // Fill the FIFO while the FSM is busy
    for (int k = 0; k < 12; k++) a_pend.push_back('{2'd0, 8'(8'h30 + k)});
    for (i = 0; i < 100 && fifo_count != 4'd8; i++) begin @(negedge clk); #1; end
    check("t3_full_reached", 32'(fifo_count), 32'd8);
    check("t3_full_a_ready", 32'(a_ready), 32'd0);
    check("t3_full_b_ready", 32'(b_ready), 32'd0);
    for (i = 0; i < 100 && fifo_count != 4'd7; i++) begin @(negedge clk); #1; end
    check("t3_pop_seen", 32'(fifo_count), 32'd7);
    n0 = n_acc;
    @(negedge clk); #1;
    check("t3_refill", 32'(fifo_count), 32'd8);
    check("t3_one_push", 32'(n_acc - n0), 32'd1);
    drain("t3_drain");

    // TRANSFER 'E' then CHAR_R2 'T'
    base = log_q.size();
    b_pend.push_back('{2'd2, 8'h45});
    b_pend.push_back('{2'd1, 8'h54});
    drain("t4_drain");
    check("t4_nstrobes", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      check("t4_kind0", 32'(log_q[base].kind), 32'd1);
      check("t4_xchar", 32'(log_q[base].data), 32'h45);
      check("t4_kind1", 32'(log_q[base + 1].kind), 32'd0);
      check("t4_char", 32'(log_q[base + 1].data), 32'h54);
      check("t4_row2", 32'(log_q[base + 1].row2), 32'd1);
      check("t4_spacing", 32'(log_q[base + 1].cyc - log_q[base].cyc >= int'(HOLD + GAP)), 32'd1);
    end

    // Reset in the middle of a CLEAR strobe with three events queued
    a_pend.push_back('{2'd3, 8'h00});
    a_pend.push_back('{2'd0, 8'h78});
    a_pend.push_back('{2'd0, 8'h79});
    a_pend.push_back('{2'd0, 8'h7a});
    for (i = 0; i < 100 && !clear; i++) begin @(negedge clk); #1; end
    check("t5_clear_seen", 32'(clear), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("t5_queued", 32'(fifo_count), 32'd3);
    a_pend.delete();
    rst = 1'b1;
    #1;
    check("t5_clear_drop", 32'(clear), 32'd0);
    check("t5_count_zero", 32'(fifo_count), 32'd0);
    check("t5_a_ready", 32'(a_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = log_q.size();
    repeat (30) @(negedge clk);
    #1;
    check("t5_no_strobes", 32'(log_q.size() - base), 32'd0);
    check("t5_count_after", 32'(fifo_count), 32'd0);

    // Five chars then CLEAR
    base = log_q.size();
    for (int k = 0; k < 5; k++) a_pend.push_back('{2'd0, 8'(8'h31 + k)});
    a_pend.push_back('{2'd3, 8'h00});
    n0 = n_acc;
    for (i = 0; i < 100 && n_acc < n0 + 6; i++) begin @(negedge clk); #1; end
`ifdef CLEAR_FLUSH_EN
    check("t6_count", 32'(fifo_count), 32'd1);
    drain("t6_drain");
    check("t6_nstrobes", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() >= base + 2) begin
      check("t6_first", 32'(log_q[base].data), 32'h31);
      check("t6_clear", 32'(log_q[base + 1].kind), 32'd2);
      check("t6_clear_time", 32'(log_q[base + 1].cyc - log_q[base].cyc), 32'd9);
    end
`else
    check("t6_count", 32'(fifo_count), 32'd5);
    drain("t6_drain");
    check("t6_nstrobes", 32'(log_q.size() - base), 32'd6);
    if (log_q.size() >= base + 6) begin
      for (int k = 0; k < 5; k++) check("t6_char", 32'(log_q[base + k].data), 32'(8'h31 + k));
      check("t6_clear", 32'(log_q[base + 5].kind), 32'd2);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
